burst_read_master: RTL
======================

# burst_read_master

Avalon-MM pipelined burst read master, the read-side counterpart of the fabric's burst write master. On a control command it issues one burst read to SDRAM through the interconnect and collects the returning beats into an internal show-ahead FIFO. The downstream consumer drains that FIFO. A burst is issued only when the FIFO can absorb all of its beats, so `master_readdatavalid` never needs back-pressure.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 32: width of the byte address.
- `DATA_WIDTH`, 32: beat width. Legal values are 16, 32, 64 or 128.
- `BYTE_ENABLE_WIDTH`, 4: equals `DATA_WIDTH/8`.
- `BURST_WIDTH`, 4: burstcount width. Maximum burst is 2^(BURST_WIDTH-1) = 8.
- `FIFO_DEPTH_LOG2`, 4: FIFO holds 16 words. Must satisfy 2^FIFO_DEPTH_LOG2 >= 2^(BURST_WIDTH-1).

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-high.
- `master_address`  out  ADDRESS_WIDTH  burst start address.
- `master_read`  out  1  read request.
- `master_burstcount`  out  BURST_WIDTH  beats requested.
- `master_byteenable`  out  BYTE_ENABLE_WIDTH  constant all ones.
- `master_waitrequest`  in  1  slave stall.
- `master_readdata`  in  DATA_WIDTH  returned beat.
- `master_readdatavalid`  in  1  beat valid.
- `ctrl_start`  in  1  command strobe.
- `ctrl_baseaddress`  in  ADDRESS_WIDTH  burst address.
- `ctrl_burstcount`  in  BURST_WIDTH  beat count, range 1..2^(BURST_WIDTH-1).
- `ctrl_busy`  out  1  command in progress.
- `ctrl_done`  out  1  one-cycle pulse after the last beat is captured.
- `user_read`  in  1  pop strobe.
- `user_readdata`  out  DATA_WIDTH  FIFO head word.
- `user_empty`  out  1  FIFO empty.
- `ctrl_error`  out  1  present only when `BURST_READ_PATTERN_CHECK_EN` is defined.

## Operation
- The state machine has four states: IDLE, WAIT_SPACE, REQ and DATA.
- IDLE:
  - `ctrl_start=1` with `ctrl_burstcount!=0` latches address and count, sets `ctrl_busy=1`, and moves to WAIT_SPACE.
  - `ctrl_start` with `ctrl_burstcount=0` is ignored.
- WAIT_SPACE: when free = 2^FIFO_DEPTH_LOG2 - used is >= the latched count, the block drives `master_read=1` with the latched address and count, and moves to REQ.
- REQ: `master_read` and the command signals are held stable until a cycle with `master_waitrequest=0`. On that edge `master_read` drops to 0 and the state moves to DATA.
- DATA:
  - Each `master_readdatavalid=1` pushes `master_readdata` into the FIFO and increments the beat counter.
  - On the beat that equals the count, the next edge gives `ctrl_busy=0` and `ctrl_done=1` for one cycle, and the state returns to IDLE.
- `ctrl_start` while `ctrl_busy=1` is ignored.
- `master_readdatavalid` outside DATA is ignored and not pushed.
- FIFO:
  - `user_readdata` shows the head word whenever `user_empty=0`.
  - `user_read=1` with `user_empty=0` pops at the edge.
  - `user_read` while empty is ignored.
  - Simultaneous push and pop leaves the occupancy unchanged. This is legal at full occupancy because space is reserved before the request.
  - Pointers wrap modulo 2^FIFO_DEPTH_LOG2. The occupancy counter is FIFO_DEPTH_LOG2+1 bits.
- Reset at any point: the FSM returns to IDLE, the FIFO is flushed, and any outstanding beats are lost. Software must not reset mid-burst on a live fabric.

## Timing
- Reset values: `master_address=0`, `master_read=0`, `master_burstcount=0`, `ctrl_busy=0`, `ctrl_done=0`, `user_empty=1`, `ctrl_error=0`. `master_byteenable` is all ones at all times. `user_readdata` is don't-care while empty.
- `ctrl_start` sampled at edge T with enough space gives `ctrl_busy=1` and `master_read=1` at T+1. The one cycle in WAIT_SPACE is skipped by evaluating space in IDLE.
- The request is accepted at the first edge with `master_read=1` and `master_waitrequest=0`. `master_read=0` follows one cycle later.
- A beat captured at edge E gives `user_empty=0` at E+1; the FIFO has no read-latency cycle.
- Last beat at edge E gives `ctrl_done=1` and `ctrl_busy=0` during E+1. A new `ctrl_start` is accepted from E+1.

## Configuration
- Macro: `BURST_READ_PATTERN_CHECK_EN`.
- Defined:
  - Adds the `ctrl_error` output.
  - Within each burst, every beat after the first must equal the previous beat + 1, mod 2^DATA_WIDTH. This matches the write master's incrementing pattern.
  - A mismatch sets `ctrl_error=1` at the next edge. `ctrl_error` is sticky and clears only on an accepted `ctrl_start` or on `reset`.
- Undefined: no `ctrl_error` port and no comparator logic. FIFO and FSM behaviour are identical in both builds.

## Test plan
- Basic burst: start with addr=0x100, count=4; slave holds waitrequest 2 cycles, then returns 19,20,21,22 -> `master_address=0x100` and `master_burstcount=4` held stable through the stall, `ctrl_done` pulses once, and the FIFO pops 19,20,21,22 in order.
- Back-pressure: pre-fill the FIFO with 12 words, then start count=8 -> stays in WAIT_SPACE with `master_read=0`. Pop 4 words -> `master_read=1` the cycle after free reaches 8.
- Stray inputs: `ctrl_start` during busy, and `ctrl_burstcount=0` while idle -> both ignored, with no extra bus request.
- Wrap-around: run 5 bursts of 8 beats with continuous `user_read` -> 40 words are popped with no loss or duplication across pointer wrap, and full with simultaneous push and pop is exercised.
- Reset mid-burst: assert `reset` after 2 of 8 beats -> all outputs return to reset values and `user_empty=1`. A next start with count=2 completes normally.
- Pattern check: with `BURST_READ_PATTERN_CHECK_EN` defined, return 5,6,8,9 -> `ctrl_error=1` after the third beat, stays set after `ctrl_done`, and clears on the next accepted start.

Source files
------------

// File: rtl/burst_read_master_if.sv
// Avalon-MM pipelined burst read bus between burst_read_master and the fabric.
// The master modport is the read master's view; the slave modport is the interconnect's view.
interface burst_read_master_if #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int BYTE_ENABLE_WIDTH = 4,
  parameter int BURST_WIDTH       = 4
);
  logic [ADDRESS_WIDTH-1:0]     master_address;
  logic                         master_read;
  logic [BURST_WIDTH-1:0]       master_burstcount;
  logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable;
  logic                         master_waitrequest;
  logic [DATA_WIDTH-1:0]        master_readdata;
  logic                         master_readdatavalid;

  modport master (
    output master_address,
    output master_read,
    output master_burstcount,
    output master_byteenable,
    input  master_waitrequest,
    input  master_readdata,
    input  master_readdatavalid
  );

  modport slave (
    input  master_address,
    input  master_read,
    input  master_burstcount,
    input  master_byteenable,
    output master_waitrequest,
    output master_readdata,
    output master_readdatavalid
  );
endinterface

// File: rtl/burst_read_master.sv
// Avalon-MM burst read master: one burst per command, beats land in a show-ahead FIFO.
// Optional macro BURST_READ_PATTERN_CHECK_EN adds ctrl_error for incrementing-data checking.
module burst_read_master #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int BYTE_ENABLE_WIDTH = 4,
  parameter int BURST_WIDTH       = 4,
  parameter int FIFO_DEPTH_LOG2   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  burst_read_master_if.master      bus,
  input  logic                     ctrl_start,
  input  logic [ADDRESS_WIDTH-1:0] ctrl_baseaddress,
  input  logic [BURST_WIDTH-1:0]   ctrl_burstcount,
  output logic                     ctrl_busy,
  output logic                     ctrl_done,
  input  logic                     user_read,
  output logic [DATA_WIDTH-1:0]    user_readdata,
  output logic                     user_empty
`ifdef BURST_READ_PATTERN_CHECK_EN
  ,
  output logic                     ctrl_error
`endif
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int UW    = FIFO_DEPTH_LOG2 + 1;
  localparam int CW    = (UW > BURST_WIDTH) ? UW : BURST_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    REQ,
    DATA
  } state_t;

  state_t                     state_q;
  logic [ADDRESS_WIDTH-1:0]   address_q;
  logic                       read_q;
  logic [BURST_WIDTH-1:0]     burst_q;
  logic [BURST_WIDTH-1:0]     beatCnt_q;
  logic                       busy_q;
  logic                       done_q;

  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wrPtr_q;
  logic [FIFO_DEPTH_LOG2-1:0] rdPtr_q;
  logic [UW-1:0]              used_q;
  logic [UW-1:0]              used_d;

  logic                       push;
  logic                       pop;
  logic                       startOk;
  logic [BURST_WIDTH-1:0]     beatNext;
  logic [UW-1:0]              free;
  logic [CW-1:0]              freeExt;

  assign push     = (state_q == DATA) && bus.master_readdatavalid;
  assign pop      = user_read && (used_q != '0);
  assign startOk  = ctrl_start && (ctrl_burstcount != '0);
  assign beatNext = beatCnt_q + BURST_WIDTH'(1);
  assign free     = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}} - used_q;
  assign freeExt  = CW'(free);

  // Space is checked in IDLE too, so a start with room goes straight to REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      address_q <= '0;
      read_q    <= 1'b0;
      burst_q   <= '0;
      beatCnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startOk) begin
            address_q <= ctrl_baseaddress;
            burst_q   <= ctrl_burstcount;
            beatCnt_q <= '0;
            busy_q    <= 1'b1;
            if (freeExt >= CW'(ctrl_burstcount)) begin
              read_q  <= 1'b1;
              state_q <= REQ;
            end else begin
              state_q <= WAIT_SPACE;
            end
          end
        end
        WAIT_SPACE: begin
          if (freeExt >= CW'(burst_q)) begin
            read_q  <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (!bus.master_waitrequest) begin
            read_q  <= 1'b0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (push) begin
            beatCnt_q <= beatNext;
            if (beatNext == burst_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    used_d = used_q;
    if (push && !pop) begin
      used_d = used_q + UW'(1);
    end else if (pop && !push) begin
      used_d = used_q - UW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      used_q  <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + FIFO_DEPTH_LOG2'(1);
      if (pop)  rdPtr_q <= rdPtr_q + FIFO_DEPTH_LOG2'(1);
      used_q <= used_d;
    end
  end

  // Storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr_q] <= bus.master_readdata;
  end

`ifdef BURST_READ_PATTERN_CHECK_EN
  logic [DATA_WIDTH-1:0] prevBeat_q;
  logic                  error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prevBeat_q <= '0;
      error_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && startOk) begin
        error_q <= 1'b0;
      end else if (push && beatCnt_q != '0 &&
                   bus.master_readdata != prevBeat_q + DATA_WIDTH'(1)) begin
        error_q <= 1'b1;
      end
      if (push) prevBeat_q <= bus.master_readdata;
    end
  end

  assign ctrl_error = error_q;
`endif

  assign bus.master_address    = address_q;
  assign bus.master_read       = read_q;
  assign bus.master_burstcount = burst_q;
  assign bus.master_byteenable = {BYTE_ENABLE_WIDTH{1'b1}};
  assign ctrl_busy             = busy_q;
  assign ctrl_done             = done_q;
  assign user_readdata         = mem[rdPtr_q];
  assign user_empty            = (used_q == '0);

endmodule
